// File: rtl/tl_pkg.sv
// Shared definitions for the main/side traffic-phase timer: phase codes,
// lamp encodings, lamp decode and parameter legality helpers.
package tl_pkg;

  typedef enum logic [2:0] {
    PH_MAIN_GREEN  = 3'd0,
    PH_MAIN_YELLOW = 3'd1,
    PH_ALLRED_A    = 3'd2,
    PH_SIDE_GREEN  = 3'd3,
    PH_SIDE_YELLOW = 3'd4,
    PH_ALLRED_B    = 3'd5,
    PH_FLASH       = 3'd6
  } phase_e;

  localparam logic [1:0] LAMP_RED = 2'b00;
  localparam logic [1:0] LAMP_YEL = 2'b01;
  localparam logic [1:0] LAMP_GRN = 2'b10;
  localparam logic [1:0] LAMP_OFF = 2'b11;

  typedef struct packed {
    logic [1:0] main_l;
    logic [1:0] side_l;
  } lamps_t;

  // A phase duration must be at least one tick and its reload value (t-1)
  // must fit in a w-bit counter.
  function automatic bit dur_ok(input int unsigned t, input int unsigned w);
    return (t >= 1) && (longint'(t) <= (longint'(1) << w));
  endfunction

  // The accumulated extension total is held in a w-bit register.
  function automatic bit ext_cap_ok(input int unsigned t_max_ext, input int unsigned w);
    return longint'(t_max_ext) < (longint'(1) << w);
  endfunction

  // Lamp pattern for a phase; lit only matters in flash mode.
  function automatic lamps_t lamp_decode(input phase_e ph, input logic lit);
    lamps_t l;
    l = '{main_l: LAMP_RED, side_l: LAMP_RED};
    case (ph)
      PH_MAIN_GREEN:  l.main_l = LAMP_GRN;
      PH_MAIN_YELLOW: l.main_l = LAMP_YEL;
      PH_SIDE_GREEN:  l.side_l = LAMP_GRN;
      PH_SIDE_YELLOW: l.side_l = LAMP_YEL;
      PH_FLASH: begin
        l.main_l = lit ? LAMP_YEL : LAMP_OFF;
        l.side_l = lit ? LAMP_RED : LAMP_OFF;
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_phase_counter.sv
// Loadable down-counter for phase timing. A load wins over counting; the
// count decrements on tick and stops at zero.
module tl_phase_counter #(
  parameter int unsigned        CNT_W   = 8,
  parameter logic [CNT_W-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // Count register: reload on state entry or extension, else tick down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/tl_phase_timer.sv
// Two-approach traffic-phase timer. Main road rests in green; a latched
// side request is served after the minimum main green, via yellow and
// all-red clearance. Side green extends while cars keep arriving, up to
// a cap. Flash mode overrides everything. All outputs are registered.
module tl_phase_timer
  import tl_pkg::*;
#(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned T_MIN_GREEN  = 30,
  parameter int unsigned T_YELLOW     = 5,
  parameter int unsigned T_ALLRED     = 2,
  parameter int unsigned T_SIDE_GREEN = 10,
  parameter int unsigned T_EXT        = 5,
  parameter int unsigned T_MAX_EXT    = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             side_car,
  input  logic             flash,
  output logic [1:0]       main_light,
  output logic [1:0]       side_light,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] remaining,
  output logic             phase_change,
  output logic             side_req
);

  localparam bit PARAMS_OK = dur_ok(T_MIN_GREEN, CNT_W) && dur_ok(T_YELLOW, CNT_W) &&
                             dur_ok(T_ALLRED, CNT_W) && dur_ok(T_SIDE_GREEN, CNT_W) &&
                             dur_ok(T_EXT, CNT_W) && dur_ok(T_MAX_EXT, CNT_W) &&
                             ext_cap_ok(T_MAX_EXT, CNT_W);

  if (!PARAMS_OK) begin : g_bad_params
    $error("tl_phase_timer: timing parameters out of range for CNT_W");
  end

  localparam int unsigned EW = CNT_W + 1;

  // Counter reload values: a phase of T ticks starts at T-1.
  localparam logic [CNT_W-1:0] LD_MIN_GREEN  = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW     = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED     = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] LD_SIDE_GREEN = CNT_W'(T_SIDE_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_EXT        = CNT_W'(T_EXT - 1);
  localparam logic [EW-1:0]    EXT_STEP      = EW'(T_EXT);
  localparam logic [EW-1:0]    EXT_CAP       = EW'(T_MAX_EXT);

  function automatic logic [CNT_W-1:0] load_for(input phase_e ph);
    case (ph)
      PH_MAIN_GREEN:  return LD_MIN_GREEN;
      PH_MAIN_YELLOW: return LD_YELLOW;
      PH_ALLRED_A:    return LD_ALLRED;
      PH_SIDE_GREEN:  return LD_SIDE_GREEN;
      PH_SIDE_YELLOW: return LD_YELLOW;
      PH_ALLRED_B:    return LD_ALLRED;
      default:        return '0;
    endcase
  endfunction

  phase_e           state_q, state_d;
  logic             side_req_q, side_req_d;
  logic [CNT_W-1:0] ext_q, ext_d;
  logic [EW-1:0]    ext_sum;
  logic             ext_fits;
  logic             lit_q, lit_d;
  lamps_t           lamps_q, lamps_d;
  logic             pc_q;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             phase_end;
  logic             entering_side;

  tl_phase_counter #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_MIN_GREEN)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  assign phase_end = tick && cnt_zero;
  assign ext_sum   = {1'b0, ext_q} + EXT_STEP;
  assign ext_fits  = (ext_sum <= EXT_CAP);

  // Next phase, counter reload and extension accounting.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // can leave one unassigned and infer a latch.
    state_d      = state_q;
    ext_d        = ext_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;

    if (flash && (state_q != PH_FLASH)) begin
      state_d = PH_FLASH;
    end else if (!flash && (state_q == PH_FLASH)) begin
      state_d = PH_ALLRED_B;
    end else if (phase_end) begin
      case (state_q)
        PH_MAIN_GREEN:  if (side_req_q) state_d = PH_MAIN_YELLOW;
        PH_MAIN_YELLOW: state_d = PH_ALLRED_A;
        PH_ALLRED_A:    state_d = PH_SIDE_GREEN;
        PH_SIDE_GREEN: begin
          if (side_car && ext_fits) begin
            cnt_load     = 1'b1;
            cnt_load_val = LD_EXT;
            ext_d        = ext_sum[CNT_W-1:0];
          end else begin
            state_d = PH_SIDE_YELLOW;
          end
        end
        PH_SIDE_YELLOW: state_d = PH_ALLRED_B;
        PH_ALLRED_B:    state_d = PH_MAIN_GREEN;
        default:        ;
      endcase
    end

    if (state_d != state_q) begin
      cnt_load     = 1'b1;
      cnt_load_val = load_for(state_d);
    end

    entering_side = (state_d == PH_SIDE_GREEN) && (state_q != PH_SIDE_GREEN);
    if (entering_side) ext_d = '0;
  end

  // Request latch, flash blink phase and the lamp pattern for the next cycle.
  always_comb begin
    side_req_d = side_req_q;
    if (side_car && (state_q != PH_SIDE_GREEN)) begin
      side_req_d = 1'b1;
    end else if (entering_side) begin
      side_req_d = 1'b0;
    end

    lit_d = lit_q;
    if ((state_d == PH_FLASH) && (state_q != PH_FLASH)) begin
      lit_d = 1'b1;
    end else if ((state_q == PH_FLASH) && tick) begin
      lit_d = ~lit_q;
    end

    lamps_d = lamp_decode(state_d, lit_d);
  end

  // Registered state and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PH_MAIN_GREEN;
      side_req_q <= 1'b0;
      ext_q      <= '0;
      lit_q      <= 1'b1;
      lamps_q    <= '{main_l: LAMP_GRN, side_l: LAMP_RED};
      pc_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      side_req_q <= side_req_d;
      ext_q      <= ext_d;
      lit_q      <= lit_d;
      lamps_q    <= lamps_d;
      pc_q       <= (state_d != state_q);
    end
  end

  assign main_light   = lamps_q.main_l;
  assign side_light   = lamps_q.side_l;
  assign phase        = state_q;
  assign remaining    = cnt;
  assign phase_change = pc_q;
  assign side_req     = side_req_q;

endmodule

// File: doc/tl_phase_timer.md
# tl_phase_timer

Parametrised two-approach traffic-phase timer for a main/side intersection. Main road rests in green. A side-road vehicle request is served after a minimum main green, with yellow and all-red clearance phases. Side green is extended while vehicles keep arriving, up to a cap. A flash (fault/night) mode is included. The block sits between the vehicle-detector inputs and the lamp drivers, and counts on an external tick strobe.

## Interface
- CNT_W, 8: width of phase down-counter and `remaining` output
- T_MIN_GREEN, 30: minimum main-green ticks
- T_YELLOW, 5: yellow ticks, both approaches
- T_ALLRED, 2: all-red clearance ticks
- T_SIDE_GREEN, 10: base side-green ticks
- T_EXT, 5: ticks added per side-green extension
- T_MAX_EXT, 20: cap on total extension ticks per side-green phase
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- tick  in  1  single-cycle count-enable strobe; all timing advances only on cycles with tick=1
- side_car  in  1  side-road vehicle detector, level
- flash  in  1  flash-mode request, level
- main_light  out  2  main lamp: 00 red, 01 yellow, 10 green, 11 off
- side_light  out  2  side lamp, same encoding
- phase  out  3  current state code
- remaining  out  CNT_W  ticks left in current phase minus one
- phase_change  out  1  one-cycle pulse in the first cycle of a new state
- side_req  out  1  latched side-service request

## Operation
- States and codes:
  - 0 MAIN_GREEN
  - 1 MAIN_YELLOW
  - 2 ALLRED_A
  - 3 SIDE_GREEN
  - 4 SIDE_YELLOW
  - 5 ALLRED_B
  - 6 FLASH
- Lamps:
  - MAIN_GREEN: main 10 / side 00
  - MAIN_YELLOW: 01 / 00
  - ALLRED_A, ALLRED_B: 00 / 00
  - SIDE_GREEN: 00 / 10
  - SIDE_YELLOW: 00 / 01
  - FLASH: main alternates 01/11, side alternates 00/11; both toggle on each tick, starting lit.
- On state entry, counter loads T_x−1. On tick with counter>0, it decrements. A tick with counter==0 is the phase end.
- MAIN_GREEN phase end:
  - side_req=1: go to MAIN_YELLOW.
  - side_req=0: stay, counter holds at 0 (rest).
  - A request arriving during rest is served at the next tick.
- MAIN_YELLOW → ALLRED_A → SIDE_GREEN at each phase end.
- SIDE_GREEN phase end:
  - side_car=1 and ext_used+T_EXT ≤ T_MAX_EXT: reload T_EXT−1 and add T_EXT to ext_used. This is not a state change; no phase_change pulse.
  - Otherwise: go to SIDE_YELLOW.
- ext_used clears on entry to SIDE_GREEN.
- SIDE_YELLOW → ALLRED_B → MAIN_GREEN.
- side_req:
  - Set on any cycle with side_car=1 while state ≠ SIDE_GREEN.
  - Cleared on entry to SIDE_GREEN.
  - Set takes priority over clear in the same cycle only if state ≠ SIDE_GREEN.
- flash:
  - flash=1 in any state except FLASH: FLASH on the next clock, regardless of tick.
  - flash=0 in FLASH: ALLRED_B on the next clock, then the normal sequence.
  - side_req is retained through FLASH.
- Parameter legality: all T_x ≥ 1 and ≤ 2^CNT_W; T_MAX_EXT < 2^CNT_W. Violations are caught by elaboration-time assertions.

## Timing
- Reset values:
  - phase=0 (MAIN_GREEN), remaining=T_MIN_GREEN−1
  - main_light=10, side_light=00
  - phase_change=0, side_req=0, ext_used=0, flash toggle=lit
- All outputs are registered. A transition decided on a phase-end tick is visible on the following cycle, together with phase_change=1 and the reloaded remaining.
- Dwell per state = T_x ticks exactly, for any tick spacing.
- tick=0: everything holds except side_req latching and flash entry/exit.
- Simultaneous flash and phase end: flash wins.
- Simultaneous side_car and the SIDE_GREEN extension decision: the sampled side_car value decides.
- rst_n assertion mid-phase returns immediately (asynchronously) to reset values. Release is synchronised externally.

## Structure
- Shared package tl_pkg holds:
  - phase enum codes
  - lamp encoding constants (LAMP_RED, LAMP_YEL, LAMP_GRN, LAMP_OFF)
  - extension/duration helper function for parameter checks
- One sub-module, tl_phase_counter: loadable CNT_W down-counter with tick enable, load value/strobe and zero flag.
- FSM, request latch, extension accounting and lamp decode live in the top.

## Test plan
Common setup: T_MIN_GREEN=3, T_YELLOW=2, T_ALLRED=1, T_SIDE_GREEN=4, T_EXT=2, T_MAX_EXT=4, tick every cycle.
- No side_car for 50 cycles → phase stays 0, main_light=10, remaining reaches 0 at cycle 3 and holds, no phase_change.
- One-cycle side_car pulse at cycle 1 → state dwells 3,2,1,4,2,1 ticks through phases 0-1-2-3-4-5-0; six phase_change pulses; side_req clears on entry to phase 3.
- side_car held high → SIDE_GREEN lasts 4+2+2 = 8 ticks (extension capped at 4), then SIDE_YELLOW; an extension reload gives no phase_change.
- flash raised in SIDE_GREEN → FLASH next cycle; main toggles 01/11 and side 00/11 per tick. Lowering flash → ALLRED_B for 1 tick, then MAIN_GREEN with remaining=2.
- tick held low for 20 cycles mid MAIN_YELLOW → remaining and phase frozen, side_req still latches side_car.
- rst_n pulsed low mid SIDE_YELLOW → immediately phase=0, main_light=10, remaining=2, side_req=0.
